// File: rtl/output_argmax_scorer.sv
`default_nettype none
// ============================================================================
// Module      : output_argmax_scorer
// Description : Serial argmax over a signed score vector, compared against a
//               teacher label; emits {hit, class} and keeps accuracy counters.
// Revision    : 1.0 - initial release
// ============================================================================
module output_argmax_scorer #(
    parameter int NO  = 5,
    parameter int NH1 = 6,
    parameter int WF  = 4,
    parameter int WN  = 16
) (
    input  logic                                iCLK,
    input  logic                                iRST,
    input  logic                                iClear,
    input  logic                                iValid_AM_Output,
    output logic                                oReady_AM_Output,
    input  logic [NO*($clog2(NH1)+WF)-1:0]      iData_AM_Output,
    input  logic                                iValid_AS_Label,
    output logic                                oReady_AS_Label,
    input  logic [$clog2(NO)-1:0]               iData_AS_Label,
    output logic                                oValid_BM_Class,
    input  logic                                iReady_BM_Class,
    output logic [$clog2(NO):0]                 oData_BM_Class,
    output logic [WN-1:0]                       oCount_Total,
    output logic [WN-1:0]                       oCount_Hit
);

    localparam int WO = $clog2(NH1) + WF;
    localparam int WC = $clog2(NO);

    localparam logic [1:0]    c_idle    = 2'd0;
    localparam logic [1:0]    c_scan    = 2'd1;
    localparam logic [1:0]    c_out     = 2'd2;
    localparam logic [WN-1:0] c_cnt_max = '1;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [NO*WO-1:0]       r_vec;
    logic [WC-1:0]          r_label;
    logic signed [WO-1:0]   r_max;
    logic [WC-1:0]          r_idx;
    logic [WC-1:0]          r_k;
    logic signed [WO-1:0]   w_elem;
    logic                   w_accept;
    logic                   w_hs;
    logic                   w_hit;

    // A label outside 0..NO-1 can never equal an index, so it never hits.
    assign w_hit = (r_idx == r_label);

    always_comb begin
        w_elem = '0;
        for (int k = 0; k < NO; k++) begin
            if (r_k == WC'(k)) begin
                w_elem = r_vec[k*WO +: WO];
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Readies are cross-coupled in IDLE so the two streams only move together.
    always_comb begin
        w_state_nxt      = r_state;
        w_accept         = 1'b0;
        w_hs             = 1'b0;
        oReady_AM_Output = 1'b0;
        oReady_AS_Label  = 1'b0;
        oValid_BM_Class  = 1'b0;
        oData_BM_Class   = '0;
        case (r_state)
            c_idle: begin
                oReady_AM_Output = iValid_AS_Label & ~iRST;
                oReady_AS_Label  = iValid_AM_Output & ~iRST;
                if (iValid_AM_Output && iValid_AS_Label) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_scan;
                end
            end
            c_scan: begin
                if (r_k == WC'(NO - 1)) begin
                    w_state_nxt = c_out;
                end
            end
            c_out: begin
                oValid_BM_Class = 1'b1;
                oData_BM_Class  = {w_hit, r_idx};
                if (iReady_BM_Class) begin
                    w_hs        = 1'b1;
                    w_state_nxt = c_idle;
                end
            end
            default: w_state_nxt = c_idle;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_vec   <= '0;
            r_label <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_k     <= '0;
        end else if (w_accept) begin
            r_vec   <= iData_AM_Output;
            r_label <= iData_AS_Label;
            r_max   <= iData_AM_Output[WO-1:0];
            r_idx   <= '0;
            r_k     <= WC'(1);
        end else if (r_state == c_scan) begin
            // Strict compare: on a tie the earlier (lower) index is kept.
            if (w_elem > r_max) begin
                r_max <= w_elem;
                r_idx <= r_k;
            end
            r_k <= r_k + 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oCount_Total <= '0;
            oCount_Hit   <= '0;
        end else if (iClear) begin
            oCount_Total <= {{(WN-1){1'b0}}, w_hs};
            oCount_Hit   <= {{(WN-1){1'b0}}, w_hs & w_hit};
        end else if (w_hs) begin
            if (oCount_Total != c_cnt_max) begin
                oCount_Total <= oCount_Total + 1'b1;
            end
            if (w_hit && (oCount_Hit != c_cnt_max)) begin
                oCount_Hit <= oCount_Hit + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_argmax_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_argmax_scorer
// Description : Self-checking bench for output_argmax_scorer against a
//               cycle-level behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_argmax_scorer;

    localparam int NO = 5;
    localparam int WO = 7;
    localparam int WC = 3;
    localparam int WN = 4;
    localparam int CMAX = (1 << WN) - 1;

    logic             clk;
    logic             rst;
    logic             clr;
    logic             vam;
    logic             rdy_am;
    logic [NO*WO-1:0] d_am;
    logic             vlab;
    logic             rdy_lab;
    logic [WC-1:0]    d_lab;
    logic             vbm;
    logic             rbm;
    logic [WC:0]      d_bm;
    logic [WN-1:0]    cnt_tot;
    logic [WN-1:0]    cnt_hit;

    int n_total = 0;
    int n_bad   = 0;
    bit started = 0;

    int sc [NO];
    int lab;

    // model state
    bit m_busy  = 0;
    int m_age   = 0;
    int m_idx   = 0;
    bit m_hitb  = 0;
    int m_total = 0;
    int m_hit   = 0;

    output_argmax_scorer #(.NO(NO), .NH1(6), .WF(4), .WN(WN)) dut (
        .iCLK            (clk),
        .iRST            (rst),
        .iClear          (clr),
        .iValid_AM_Output(vam),
        .oReady_AM_Output(rdy_am),
        .iData_AM_Output (d_am),
        .iValid_AS_Label (vlab),
        .oReady_AS_Label (rdy_lab),
        .iData_AS_Label  (d_lab),
        .oValid_BM_Class (vbm),
        .iReady_BM_Class (rbm),
        .oData_BM_Class  (d_bm),
        .oCount_Total    (cnt_tot),
        .oCount_Hit      (cnt_hit)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int argmax(input int s [NO]);
        int best = 0;
        for (int k = 1; k < NO; k++) if (s[k] > s[best]) best = k;
        return best;
    endfunction

    function automatic bit m_valid();
        return m_busy && (m_age >= NO - 1);
    endfunction

    task automatic set_scores(input int s [NO]);
        for (int k = 0; k < NO; k++) begin
            sc[k] = s[k];
            d_am[k*WO +: WO] = WO'(s[k]);
        end
    endtask

    task automatic set_label(input int l);
        lab   = l;
        d_lab = WC'(l);
    endtask

    // Model advances on the same edge as the DUT, using the inputs held there.
    task automatic model_update();
        bit hs;
        if (rst) begin
            m_busy = 0; m_total = 0; m_hit = 0;
        end else begin
            hs = m_valid() && rbm;
            if (clr) begin
                m_total = hs ? 1 : 0;
                m_hit   = (hs && m_hitb) ? 1 : 0;
            end else if (hs) begin
                if (m_total < CMAX) m_total++;
                if (m_hitb && m_hit < CMAX) m_hit++;
            end
            if (hs) m_busy = 0;
            else if (m_busy) m_age++;
            else if (vam && vlab) begin
                m_busy = 1; m_age = 0;
                m_idx  = argmax(sc);
                m_hitb = (m_idx == lab);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        started = 1;
        #1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("rdy_am",  int'(rdy_am),  int'(!m_busy && vlab && !rst));
            chk("rdy_lab", int'(rdy_lab), int'(!m_busy && vam && !rst));
            chk("valid",   int'(vbm),     int'(m_valid()));
            chk("data",    int'(d_bm),    m_valid() ? ((int'(m_hitb) << WC) | m_idx) : 0);
            chk("total",   int'(cnt_tot), m_total);
            chk("hits",    int'(cnt_hit), m_hit);
        end
    end

    // Accept one sample, wait for its result and complete the handshake.
    task automatic run_sample(input int s [NO], input int l, output int data, output int lat);
        set_scores(s); set_label(l);
        vam = 1; vlab = 1; rbm = 1;
        tick();
        vam = 0; vlab = 0;
        lat = 0;
        while (!vbm && lat < 20) begin tick(); lat++; end
        if (lat >= 20) chk("result_timeout", 0, 1);
        data = int'(d_bm);
        tick();
    endtask

    initial begin
        int data, lat, d0, t0, w;
        int v1 [NO] = '{3, -2, 10, 4, 9};
        int v2 [NO] = '{5, 5, -1, 5, 0};
        int v3 [NO] = '{-8, -3, -64, -5, -9};
        int vr [NO];

        rst = 1; clr = 0; vam = 1; vlab = 1; rbm = 0;
        set_scores(v1); set_label(2);
        tick(); tick();
        chk("rst_rdy_am", int'(rdy_am), 0);
        chk("rst_rdy_lab", int'(rdy_lab), 0);
        chk("rst_valid", int'(vbm), 0);
        chk("rst_data", int'(d_bm), 0);
        chk("rst_total", int'(cnt_tot), 0);
        rst = 0; vam = 0; vlab = 0;
        tick();

        run_sample(v1, 2, data, lat);
        chk("t1_latency", lat, NO - 1);
        chk("t1_data", data, 4'b1010);
        chk("t1_total", int'(cnt_tot), 1);
        chk("t1_hit", int'(cnt_hit), 1);

        run_sample(v2, 1, data, lat);
        chk("t2_tie", data, 4'b0000);
        run_sample(v3, 3, data, lat);
        chk("t2_neg", data, 4'b0001);
        chk("t2_total", int'(cnt_tot), 3);
        chk("t2_hit", int'(cnt_hit), 1);

        // Output vector alone is held until the label shows up.
        set_scores(v1); vam = 1; vlab = 0; rbm = 1;
        repeat (10) begin
            tick();
            chk("t3_rdy_am", int'(rdy_am), 0);
            chk("t3_valid", int'(vbm), 0);
        end
        set_label(4); vlab = 1; #1;
        chk("t3_join_am", int'(rdy_am), 1);
        chk("t3_join_lab", int'(rdy_lab), 1);
        tick();
        chk("t3_busy_am", int'(rdy_am), 0);
        chk("t3_busy_lab", int'(rdy_lab), 0);
        vam = 0; vlab = 0;
        w = 0;
        while (!vbm && w < 20) begin tick(); w++; end
        chk("t3_data", int'(d_bm), 4'b0010);
        tick();

        // Back-pressure in OUT.
        set_scores(v3); set_label(1); vam = 1; vlab = 1; rbm = 0;
        tick();
        vam = 0; vlab = 0;
        w = 0;
        while (!vbm && w < 20) begin tick(); w++; end
        d0 = int'(d_bm); t0 = int'(cnt_tot);
        chk("t4_data", d0, 4'b1001);
        repeat (7) begin
            tick();
            chk("t4_hold_data", int'(d_bm), d0);
            chk("t4_hold_valid", int'(vbm), 1);
            chk("t4_hold_total", int'(cnt_tot), t0);
        end
        rbm = 1;
        tick();
        chk("t4_after", int'(cnt_tot), t0 + 1);

        // Saturation and clear.
        clr = 1; tick(); clr = 0;
        chk("t5_clear", int'(cnt_tot), 0);
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < NO; k++) vr[k] = $urandom_range(127) - 64;
            run_sample(vr, argmax(vr), data, lat);
            if (i == 14) begin
                chk("t5_tot15", int'(cnt_tot), 15);
                chk("t5_hit15", int'(cnt_hit), 15);
            end
        end
        chk("t5_tot_sat", int'(cnt_tot), 15);
        chk("t5_hit_sat", int'(cnt_hit), 15);
        set_scores(v1); set_label(2); vam = 1; vlab = 1; rbm = 0;
        tick();
        vam = 0; vlab = 0;
        w = 0;
        while (!vbm && w < 20) begin tick(); w++; end
        clr = 1; rbm = 1;
        tick();
        clr = 0;
        chk("t5_clr_hs_tot", int'(cnt_tot), 1);
        chk("t5_clr_hs_hit", int'(cnt_hit), 1);

        // Reset in the middle of a scan.
        set_scores(v2); set_label(0); vam = 1; vlab = 1;
        tick();
        vam = 0; vlab = 0;
        tick(); tick();
        rst = 1; tick(); rst = 0;
        chk("t6_valid", int'(vbm), 0);
        chk("t6_total", int'(cnt_tot), 0);
        run_sample(v1, 2, data, lat);
        chk("t6_data", data, 4'b1010);
        chk("t6_total1", int'(cnt_tot), 1);

        // Random traffic, checked every cycle by the compare process.
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < NO; k++)
                vr[k] = ($urandom_range(2) == 0) ? int'($urandom_range(4)) - 2
                                                 : int'($urandom_range(127)) - 64;
            set_scores(vr);
            set_label(($urandom_range(1) == 0) ? argmax(vr) : int'($urandom_range(7)));
            vam  = $urandom_range(1);
            vlab = $urandom_range(1);
            rbm  = ($urandom_range(3) != 0);
            clr  = ($urandom_range(39) == 0);
            rst  = ($urandom_range(199) == 0);
            tick();
        end
        rst = 0; clr = 0; vam = 0; vlab = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
